// File: rtl/branch_resolve_unit.sv
// Branch resolution and fetch-PC stage: resolves branches and jumps, redirects on a
// mispredict, and keeps a 2-bit saturating branch-history table for fetch prediction.
module branch_resolve_unit #(
  parameter int unsigned      XLEN        = 32,
  parameter logic [XLEN-1:0]  RESET_PC    = '0,
  parameter int unsigned      BHT_ENTRIES = 16,
  parameter int unsigned      CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_i,
  input  logic             stall_i,
  input  logic             branch_i,
  input  logic             jal_i,
  input  logic             jalr_i,
  input  logic [2:0]       cond_i,
  input  logic [XLEN-1:0]  srcA_i,
  input  logic [XLEN-1:0]  srcB_i,
  input  logic [XLEN-1:0]  pcE_i,
  input  logic [XLEN-1:0]  imm_i,
  input  logic             predTaken_i,
  input  logic [XLEN-1:0]  fetchNextPc_i,
  output logic [XLEN-1:0]  pc_o,
  output logic             predTaken_o,
  output logic             flush_o,
  output logic [CNT_W-1:0] branchCount_o,
  output logic [CNT_W-1:0] mispredCount_o
);

  localparam int unsigned IdxW = $clog2(BHT_ENTRIES);

  logic            v_q, branch_q, jal_q, jalr_q, pred_q;
  logic [2:0]      cond_q;
  logic [XLEN-1:0] src_a_q, src_b_q, pc_e_q, imm_q;
  logic [XLEN-1:0] pc_q;
  logic [1:0]      bht_q [BHT_ENTRIES];
  logic [CNT_W-1:0] bcnt_q, mcnt_q;

  logic            cmp, taken, mispredict, redirect, bht_upd;
  logic [XLEN-1:0] sum, target, next_pc;
  logic [IdxW-1:0] rd_idx, wr_idx;

  always_comb begin
    cmp = 1'b0;
    case (cond_q)
      3'b000:  cmp = (src_a_q == src_b_q);
      3'b001:  cmp = (src_a_q != src_b_q);
      3'b100:  cmp = ($signed(src_a_q) <  $signed(src_b_q));
      3'b101:  cmp = ($signed(src_a_q) >= $signed(src_b_q));
      3'b110:  cmp = (src_a_q <  src_b_q);
      3'b111:  cmp = (src_a_q >= src_b_q);
      default: cmp = 1'b0;
    endcase
  end

  always_comb begin
    taken   = jal_q | jalr_q | (branch_q & cmp);
    sum     = (jalr_q ? src_a_q : pc_e_q) + imm_q;
    target  = jalr_q ? {sum[XLEN-1:1], 1'b0} : sum;
    next_pc = taken ? target : pc_e_q + XLEN'(4);
  end

  // JALR is never predicted by fetch, so it always redirects.
  always_comb begin
    mispredict = 1'b0;
    if (v_q) begin
      if (jalr_q)        mispredict = 1'b1;
      else if (jal_q)    mispredict = ~pred_q;
      else if (branch_q) mispredict = (taken != pred_q);
    end
  end

  assign redirect = mispredict & ~stall_i;
  assign bht_upd  = v_q & branch_q & ~stall_i;
  assign rd_idx   = pc_q[IdxW+1:2];
  assign wr_idx   = pc_e_q[IdxW+1:2];

  assign flush_o        = redirect;
  assign pc_o           = pc_q;
  assign predTaken_o    = bht_q[rd_idx][1];
  assign branchCount_o  = bcnt_q;
  assign mispredCount_o = mcnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q      <= 1'b0;
      branch_q <= 1'b0;
      jal_q    <= 1'b0;
      jalr_q   <= 1'b0;
      pred_q   <= 1'b0;
      cond_q   <= '0;
      src_a_q  <= '0;
      src_b_q  <= '0;
      pc_e_q   <= '0;
      imm_q    <= '0;
      pc_q     <= RESET_PC;
      bcnt_q   <= '0;
      mcnt_q   <= '0;
    end else if (!stall_i) begin
      // The slot entering during a redirect belongs to the wrong path.
      v_q      <= valid_i & ~redirect;
      branch_q <= branch_i;
      jal_q    <= jal_i;
      jalr_q   <= jalr_i;
      pred_q   <= predTaken_i;
      cond_q   <= cond_i;
      src_a_q  <= srcA_i;
      src_b_q  <= srcB_i;
      pc_e_q   <= pcE_i;
      imm_q    <= imm_i;
      pc_q     <= redirect ? next_pc : fetchNextPc_i;
      if (bht_upd)  bcnt_q <= bcnt_q + CNT_W'(1);
      if (redirect) mcnt_q <= mcnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= 2'b01;
    end else if (bht_upd) begin
      if (taken && bht_q[wr_idx] != 2'b11)       bht_q[wr_idx] <= bht_q[wr_idx] + 2'd1;
      else if (!taken && bht_q[wr_idx] != 2'b00) bht_q[wr_idx] <= bht_q[wr_idx] - 2'd1;
    end
  end

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Parametrised branch-resolution and PC-update stage for the pipelined core. It registers the resolving instruction's branch information, evaluates all RV32I conditional-branch and jump kinds, and owns the architectural fetch PC register. On a misprediction it redirects the PC and issues a squash. A 2-bit saturating branch-history table (BHT) supplies the taken prediction to fetch.

## Interface
Parameters:
- XLEN, 32, datapath/PC width
- RESET_PC, 0, value loaded into pc_o on reset
- BHT_ENTRIES, 16, predictor entries; power of two, ≥2; IDXW = log2(BHT_ENTRIES)
- CNT_W, 32, width of statistics counters

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- valid_i  in  1  instruction at stage input is valid
- stall_i  in  1  freeze all state (stage register, pc_o, BHT, counters)
- branch_i  in  1  conditional branch
- jal_i  in  1  JAL
- jalr_i  in  1  JALR
- cond_i  in  3  funct3: 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU, 010/011 never taken
- srcA_i, srcB_i  in  XLEN  compare operands (srcA_i is also the JALR base)
- pcE_i  in  XLEN  PC of the instruction
- imm_i  in  XLEN  sign-extended immediate
- predTaken_i  in  1  prediction that fetch made for this instruction
- fetchNextPc_i  in  XLEN  next PC proposed by fetch (pc+4 or predicted target)
- pc_o  out  XLEN  current fetch PC
- predTaken_o  out  1  combinational BHT lookup for pc_o: counter[pc_o[IDXW+1:2]][1]
- flush_o  out  1  squash younger instructions; high in the redirect cycle
- branchCount_o  out  CNT_W  resolved conditional branches
- mispredCount_o  out  CNT_W  redirects issued

## Operation
- Stage register: when stall_i=0, it captures all *_i instruction fields and sets vR = valid_i & ~flush_o. When stall_i=1, it holds.
- Resolution (combinational, from the registered values):
  - taken = jalR | jalrR | (branchR & cmp(cond)).
  - Signed compares are on XLEN-bit two's complement; unsigned compares are on raw bits.
- Target:
  - JALR: (srcA+imm) & ~1.
  - Otherwise: pcE+imm.
  - Sums are modulo 2^XLEN.
- Correct next PC: taken ? target : pcE+4.
- Mispredict (all conditions require vR):
  - JALR: always a mispredict.
  - JAL: mispredict when predTakenR=0.
  - Branch: mispredict when taken≠predTakenR.
- redirect = mispredict & ~stall_i. flush_o = redirect.
- pc_o update when stall_i=0: redirect ? correct next PC : fetchNextPc_i.
- BHT update: on vR & branchR & ~stall_i, entry pcE[IDXW+1:2] increments when taken (saturating at 11) and decrements when not taken (saturating at 00). JAL/JALR never update the BHT.
- Counters:
  - branchCount increments on each BHT update.
  - mispredCount increments on each redirect.
  - Both wrap modulo 2^CNT_W.
- Simultaneous events:
  - A redirect has priority over fetchNextPc_i.
  - The instruction entering the stage register in the redirect cycle is captured with vR=0, i.e. squashed.
  - A BHT read and write to the same entry in one cycle returns the old value.

## Timing
- Reset values:
  - pc_o=RESET_PC, vR=0, flush_o=0, counters=0.
  - All BHT entries=01 (weakly not-taken), so predTaken_o=0.
- Latency:
  - An instruction presented in cycle N resolves in cycle N+1, where flush_o is asserted combinationally.
  - pc_o holds the corrected value from cycle N+2.
- stall_i=1 in the resolve cycle: flush_o=0 and nothing changes. The redirect fires in the first cycle with stall_i=0.
- Reset mid-operation: everything returns immediately to reset values, and any pending redirect is lost.
- flush_o is never asserted in two consecutive cycles for the same instruction.

## Test plan
- Reset, then 3 cycles with no valid instruction and fetchNextPc_i = pc_o+4 -> pc_o = 0, 4, 8, 0xC; flush_o=0; predTaken_o=0.
- BEQ with srcA=srcB=5, pcE=0x100, imm=0x20, predTaken=0 -> flush_o high one cycle after input, pc_o=0x120 the next cycle, mispredCount=1, BHT[0]=10, predTaken_o=1 when pc_o index matches.
- BLT srcA=0xFFFFFFFF, srcB=1 -> taken; BLTU with the same operands -> not taken; with predTaken_i matching both outcomes -> no flush, pc_o follows fetchNextPc_i.
- JALR srcA=0x203, imm=0x10 -> pc_o=0x212 (bit 0 cleared), flush_o=1; the instruction in the next slot is squashed (vR=0, no BHT/counter update).
- Mispredicted BNE with stall_i=1 for 3 cycles -> flush_o=0 and pc_o frozen; redirect occurs in the cycle stall_i drops.
- Four taken branches to one index -> counter saturates at 11 after two updates; four not-taken -> 00; rst_n low mid-sequence -> pc_o=RESET_PC and counters 0 immediately.
